// File: rtl/csr_exec_unit_pkg.sv
// rtl/csr_exec_unit_pkg.sv - shared types and constants for the CSR execution unit
//
// Purpose: FSM state encoding, SYSTEM funct3 codes, CSR addresses, trap
// cause codes and the accept-time instruction classifier.
package csr_exec_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_TRAP  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // What the unit decided to do with an accepted instruction.
    typedef enum logic [1:0] {
        OP_CSR     = 2'd0,
        OP_ECALL   = 2'd1,
        OP_MRET    = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_kind_t;

    localparam logic [2:0] CSRRW  = 3'd1;
    localparam logic [2:0] CSRRS  = 3'd2;
    localparam logic [2:0] CSRRC  = 3'd3;
    localparam logic [2:0] CSRRWI = 3'd5;
    localparam logic [2:0] CSRRSI = 3'd6;
    localparam logic [2:0] CSRRCI = 3'd7;

    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;

    // ecall outranks mret; funct3 0 and 4 are not CSR ops.
    function automatic op_kind_t classify(input logic [2:0] funct3,
                                          input logic       ecall,
                                          input logic       mret);
        op_kind_t kind;
        if (ecall) begin
            kind = OP_ECALL;
        end else if (mret) begin
            kind = OP_MRET;
        end else begin
            case (funct3)
                CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI: kind = OP_CSR;
                default:                                     kind = OP_ILLEGAL;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/csr_exec_unit_alu.sv
// rtl/csr_exec_unit_alu.sv - combinational CSR new-value calculation
//
// Purpose: computes the RW/RS/RC result from the old CSR value and the
// operand (rs1 data or zero-extended zimm), plus whether the write happens.
// Ports:
//   funct3     in   instruction funct3 (bit 2 selects zimm)
//   rs1_data   in   rs1 register value
//   rs1_idx    in   rs1 index / zimm
//   old_value  in   CSR value read in the READ cycle
//   new_value  out  value to write back
//   write_en   out  0 for RS/RC with rs1_idx==0, 1 for RW
module csr_alu
    import csr_exec_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [4:0]            rs1_idx,
    input  logic [DATA_WIDTH-1:0] old_value,
    output logic [DATA_WIDTH-1:0] new_value,
    output logic                  write_en
);

    logic [DATA_WIDTH-1:0] operand;

    always_comb begin
        operand   = funct3[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_idx} : rs1_data;
        new_value = old_value;
        write_en  = 1'b0;
        case (funct3[1:0])
            2'b01: begin
                new_value = operand;
                write_en  = 1'b1;
            end
            2'b10: begin
                new_value = old_value | operand;
                write_en  = (rs1_idx != 5'd0);
            end
            2'b11: begin
                new_value = old_value & ~operand;
                write_en  = (rs1_idx != 5'd0);
            end
            default: begin
                new_value = old_value;
                write_en  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_exec_unit.sv
// rtl/csr_exec_unit.sv - SYSTEM instruction sequencer toward the CSR file
//
// Purpose: accepts a decoded SYSTEM instruction, runs CSR read/modify/write
// or a trap/mret request against the CSR file, and returns the rd writeback
// value and next-PC redirect over a valid/ready handshake.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready, in_*         decode-side instruction handshake
//   csr_addr/csr_ren/csr_rdata      CSR read (combinational read data)
//   csr_wen/csr_wdata               CSR write
//   trap_ecall/trap_mret            one-cycle trap-entry / return strobes
//   trap_epc/trap_cause             trap PC and cause (valid with trap_ecall)
//   csr_jump                        trap/return target from the CSR file
//   out_valid/out_ready, out_*      writeback-side result handshake
module csr_exec_unit
    import csr_exec_unit_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter logic [31:0] ECALL_CAUSE   = CAUSE_ECALL_M,
    parameter logic [31:0] ILLEGAL_CAUSE = CAUSE_ILLEGAL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_funct3,
    input  logic [11:0]           in_csr_addr,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [4:0]            in_rs1_idx,
    input  logic [4:0]            in_rd_idx,
    input  logic [31:0]           in_pc,
    input  logic                  in_ecall,
    input  logic                  in_mret,
    output logic [11:0]           csr_addr,
    output logic                  csr_ren,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_wen,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  trap_ecall,
    output logic [31:0]           trap_epc,
    output logic [31:0]           trap_cause,
    output logic                  trap_mret,
    input  logic [31:0]           csr_jump,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_rd_idx,
    output logic                  out_rd_wen,
    output logic [DATA_WIDTH-1:0] out_rd_wdata,
    output logic                  out_redirect,
    output logic [31:0]           out_next_pc
);

    state_t                state_q, state_d;
    op_kind_t              kind_q;
    logic [2:0]            funct3_q;
    logic [11:0]           addr_q;
    logic [DATA_WIDTH-1:0] rs1_data_q;
    logic [4:0]            rs1_idx_q;
    logic [4:0]            rd_q;
    logic [31:0]           pc_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic [31:0]           next_pc_q;

    logic [DATA_WIDTH-1:0] alu_new;
    logic                  alu_wen;
    logic                  accept;

    assign accept = (state_q == ST_IDLE) && in_valid;

    csr_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .funct3    (funct3_q),
        .rs1_data  (rs1_data_q),
        .rs1_idx   (rs1_idx_q),
        .old_value (old_q),
        .new_value (alu_new),
        .write_en  (alu_wen)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        csr_ren      = 1'b0;
        csr_wen      = 1'b0;
        csr_wdata    = '0;
        trap_ecall   = 1'b0;
        trap_mret    = 1'b0;
        trap_epc     = 32'd0;
        trap_cause   = 32'd0;
        out_valid    = 1'b0;
        out_rd_wen   = 1'b0;
        out_redirect = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (classify(in_funct3, in_ecall, in_mret) == OP_CSR)
                              ? ST_READ : ST_TRAP;
                end
            end
            ST_READ: begin
                csr_ren = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                csr_wen   = alu_wen;
                csr_wdata = alu_new;
                state_d   = ST_RESP;
            end
            ST_TRAP: begin
                trap_mret  = (kind_q == OP_MRET);
                trap_ecall = (kind_q != OP_MRET);
                trap_epc   = pc_q;
                if (kind_q == OP_ECALL) begin
                    trap_cause = ECALL_CAUSE;
                end else if (kind_q == OP_ILLEGAL) begin
                    trap_cause = ILLEGAL_CAUSE;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                out_valid    = 1'b1;
                out_rd_wen   = (kind_q == OP_CSR) && (rd_q != 5'd0);
                out_redirect = (kind_q != OP_CSR);
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q     <= OP_CSR;
            funct3_q   <= 3'd0;
            addr_q     <= 12'd0;
            rs1_data_q <= '0;
            rs1_idx_q  <= 5'd0;
            rd_q       <= 5'd0;
            pc_q       <= 32'd0;
            old_q      <= '0;
            next_pc_q  <= 32'd0;
        end else begin
            if (accept) begin
                kind_q     <= classify(in_funct3, in_ecall, in_mret);
                funct3_q   <= in_funct3;
                addr_q     <= in_csr_addr;
                rs1_data_q <= in_rs1_data;
                rs1_idx_q  <= in_rs1_idx;
                rd_q       <= in_rd_idx;
                pc_q       <= in_pc;
                // Clear result fields so a trap never reports a stale rd value
                // and a CSR op never reports a stale target.
                old_q      <= '0;
                next_pc_q  <= 32'd0;
            end
            if (state_q == ST_READ) begin
                old_q <= csr_rdata;
            end
            if (state_q == ST_TRAP) begin
                next_pc_q <= csr_jump;
            end
        end
    end

    assign csr_addr     = addr_q;
    assign out_rd_idx   = rd_q;
    assign out_rd_wdata = old_q;
    assign out_next_pc  = next_pc_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// tb/tb_csr_exec_unit.sv - self-checking bench for csr_exec_unit
module tb_csr_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [11:0] in_csr_addr;
    logic [31:0] in_rs1_data;
    logic [4:0]  in_rs1_idx;
    logic [4:0]  in_rd_idx;
    logic [31:0] in_pc;
    logic        in_ecall;
    logic        in_mret;
    logic [11:0] csr_addr;
    logic        csr_ren;
    logic [31:0] csr_rdata;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic        trap_ecall;
    logic [31:0] trap_epc;
    logic [31:0] trap_cause;
    logic        trap_mret;
    logic [31:0] csr_jump;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd_idx;
    logic        out_rd_wen;
    logic [31:0] out_rd_wdata;
    logic        out_redirect;
    logic [31:0] out_next_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_exec_unit dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_funct3    (in_funct3),
        .in_csr_addr  (in_csr_addr),
        .in_rs1_data  (in_rs1_data),
        .in_rs1_idx   (in_rs1_idx),
        .in_rd_idx    (in_rd_idx),
        .in_pc        (in_pc),
        .in_ecall     (in_ecall),
        .in_mret      (in_mret),
        .csr_addr     (csr_addr),
        .csr_ren      (csr_ren),
        .csr_rdata    (csr_rdata),
        .csr_wen      (csr_wen),
        .csr_wdata    (csr_wdata),
        .trap_ecall   (trap_ecall),
        .trap_epc     (trap_epc),
        .trap_cause   (trap_cause),
        .trap_mret    (trap_mret),
        .csr_jump     (csr_jump),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rd_idx   (out_rd_idx),
        .out_rd_wen   (out_rd_wen),
        .out_rd_wdata (out_rd_wdata),
        .out_redirect (out_redirect),
        .out_next_pc  (out_next_pc)
    );

    typedef struct {
        logic [2:0]  funct3;
        logic [11:0] addr;
        logic [31:0] rs1_data;
        logic [4:0]  rs1_idx;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic        exp_rd_wen;
    } csr_vec_t;

    typedef struct {
        logic [2:0]  funct3;
        logic        ecall;
        logic        mret;
        logic [31:0] pc;
        logic [31:0] jump;
        logic        exp_ecall;
        logic        exp_mret;
        logic [31:0] exp_cause;
    } trap_vec_t;

    csr_vec_t  cv[8];
    trap_vec_t tv[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_funct3   = 3'd0;
        in_csr_addr = 12'd0;
        in_rs1_data = 32'd0;
        in_rs1_idx  = 5'd0;
        in_rd_idx   = 5'd0;
        in_pc       = 32'd0;
        in_ecall    = 1'b0;
        in_mret     = 1'b0;
    endtask

    // Offers one CSR op at a negedge; returns #1 after the accepting edge
    // with rdata already presented for the READ cycle.
    task automatic offer_csr(input csr_vec_t v);
        @(negedge clk);
        in_valid    = 1'b1;
        in_funct3   = v.funct3;
        in_csr_addr = v.addr;
        in_rs1_data = v.rs1_data;
        in_rs1_idx  = v.rs1_idx;
        in_rd_idx   = v.rd;
        in_pc       = 32'h8000_0000;
        in_ecall    = 1'b0;
        in_mret     = 1'b0;
        csr_rdata   = v.rdata;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic run_csr(input int i, input csr_vec_t v);
        string p;
        p = $sformatf("csr[%0d]", i);
        out_ready = 1'b1;
        @(negedge clk);
        check({p, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        offer_csr(v);
        check({p, ".read_ren"}, {31'd0, csr_ren}, 32'd1);
        check({p, ".read_addr"}, {20'd0, csr_addr}, {20'd0, v.addr});
        check({p, ".read_wen"}, {31'd0, csr_wen}, 32'd0);
        check({p, ".read_in_ready"}, {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check({p, ".write_ren"}, {31'd0, csr_ren}, 32'd0);
        check({p, ".write_wen"}, {31'd0, csr_wen}, {31'd0, v.exp_wen});
        if (v.exp_wen) check({p, ".write_wdata"}, csr_wdata, v.exp_wdata);
        check({p, ".write_valid"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check({p, ".resp_valid"}, {31'd0, out_valid}, 32'd1);
        check({p, ".resp_wen_off"}, {31'd0, csr_wen}, 32'd0);
        check({p, ".resp_rd"}, {27'd0, out_rd_idx}, {27'd0, v.rd});
        check({p, ".resp_rd_wen"}, {31'd0, out_rd_wen}, {31'd0, v.exp_rd_wen});
        check({p, ".resp_rd_wdata"}, out_rd_wdata, v.rdata);
        check({p, ".resp_redirect"}, {31'd0, out_redirect}, 32'd0);
        @(posedge clk);
        #1;
        check({p, ".after_valid"}, {31'd0, out_valid}, 32'd0);
        check({p, ".after_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_trap(input int i, input trap_vec_t v);
        string p;
        p = $sformatf("trap[%0d]", i);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid    = 1'b1;
        in_funct3   = v.funct3;
        in_csr_addr = 12'h123;
        in_rs1_data = 32'h5555_5555;
        in_rs1_idx  = 5'd3;
        in_rd_idx   = 5'd7;
        in_pc       = v.pc;
        in_ecall    = v.ecall;
        in_mret     = v.mret;
        csr_jump    = v.jump;
        @(posedge clk);
        #1;
        idle_inputs();
        check({p, ".ecall"}, {31'd0, trap_ecall}, {31'd0, v.exp_ecall});
        check({p, ".mret"}, {31'd0, trap_mret}, {31'd0, v.exp_mret});
        check({p, ".epc"}, trap_epc, v.pc);
        if (v.exp_ecall) check({p, ".cause"}, trap_cause, v.exp_cause);
        check({p, ".ren"}, {31'd0, csr_ren}, 32'd0);
        check({p, ".wen"}, {31'd0, csr_wen}, 32'd0);
        @(posedge clk);
        #1;
        check({p, ".strobe_released"}, {30'd0, trap_ecall, trap_mret}, 32'd0);
        check({p, ".resp_valid"}, {31'd0, out_valid}, 32'd1);
        check({p, ".redirect"}, {31'd0, out_redirect}, 32'd1);
        check({p, ".next_pc"}, out_next_pc, v.jump);
        check({p, ".rd_wen"}, {31'd0, out_rd_wen}, 32'd0);
        @(posedge clk);
        #1;
        check({p, ".after_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        //         funct3 addr     rs1_data      idx    rd     rdata          wen   wdata          rd_wen
        cv[0] = '{3'd1, 12'h305, 32'h8000_0100, 5'd7,  5'd5, 32'h0000_0000, 1'b1, 32'h8000_0100, 1'b1};
        cv[1] = '{3'd2, 12'h300, 32'h0000_FFFF, 5'd0,  5'd3, 32'h0000_1800, 1'b0, 32'h0000_0000, 1'b1};
        cv[2] = '{3'd7, 12'h300, 32'hFFFF_FFFF, 5'd8,  5'd4, 32'h0000_1888, 1'b1, 32'h0000_1880, 1'b1};
        cv[3] = '{3'd2, 12'h341, 32'h0000_00F0, 5'd9,  5'd0, 32'h0000_000F, 1'b1, 32'h0000_00FF, 1'b0};
        cv[4] = '{3'd3, 12'h342, 32'h0000_0003, 5'd2,  5'd1, 32'h8000_000B, 1'b1, 32'h8000_0008, 1'b1};
        cv[5] = '{3'd5, 12'h305, 32'hDEAD_BEEF, 5'd31, 5'd9, 32'h1234_5678, 1'b1, 32'h0000_001F, 1'b1};
        cv[6] = '{3'd5, 12'h305, 32'hDEAD_BEEF, 5'd0,  5'd2, 32'h0000_AAAA, 1'b1, 32'h0000_0000, 1'b1};
        cv[7] = '{3'd6, 12'h300, 32'h0000_0000, 5'd16, 5'd6, 32'h0000_0001, 1'b1, 32'h0000_0011, 1'b1};

        //         funct3 ecall mret  pc             jump           ecall mret  cause
        tv[0] = '{3'd0, 1'b1, 1'b0, 32'h8000_0010, 32'h8000_0200, 1'b1, 1'b0, 32'd11};
        tv[1] = '{3'd0, 1'b0, 1'b1, 32'h8000_0200, 32'h8000_0014, 1'b0, 1'b1, 32'd0};
        tv[2] = '{3'd4, 1'b0, 1'b0, 32'h8000_0030, 32'h8000_0200, 1'b1, 1'b0, 32'd2};
        tv[3] = '{3'd0, 1'b1, 1'b1, 32'h8000_0044, 32'h8000_0200, 1'b1, 1'b0, 32'd11};
        tv[4] = '{3'd0, 1'b0, 1'b0, 32'h8000_0058, 32'h8000_0200, 1'b1, 1'b0, 32'd2};

        idle_inputs();
        reset     = 1'b1;
        out_ready = 1'b0;
        csr_rdata = 32'd0;
        csr_jump  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);
        check("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check("reset.strobes", {28'd0, csr_ren, csr_wen, trap_ecall, trap_mret}, 32'd0);
        check("reset.out_fields", {26'd0, out_rd_wen, out_redirect, out_rd_idx[3:0]}, 32'd0);
        check("reset.out_next_pc", out_next_pc, 32'd0);
        check("reset.csr_addr", {20'd0, csr_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_csr(i, cv[i]);
        for (int i = 0; i < 5; i++) run_trap(i, tv[i]);

        // Backpressure: result must hold for 5 cycles with out_ready low.
        out_ready = 1'b0;
        offer_csr(cv[4]);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold[%0d].valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("hold[%0d].in_ready", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("hold[%0d].rd_wdata", k), out_rd_wdata, 32'h8000_000B);
            check($sformatf("hold[%0d].rd", k), {26'd0, out_rd_wen, out_rd_idx}, {26'd0, 1'b1, 5'd1});
            check($sformatf("hold[%0d].wen", k), {31'd0, csr_wen}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold.release_valid", {31'd0, out_valid}, 32'd0);
        check("hold.release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset while in WRITE aborts without a write strobe afterwards.
        offer_csr(cv[0]);
        @(posedge clk);
        #1;
        check("abort.in_write", {31'd0, csr_wen}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort.wen", {31'd0, csr_wen}, 32'd0);
        check("abort.valid", {31'd0, out_valid}, 32'd0);
        check("abort.in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort.stays_idle", {30'd0, out_valid, csr_wen}, 32'd0);

        // Unit still works after the abort.
        run_csr(8, cv[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
